// File: rtl/enigma_pkg.sv
// Shared types, modular helpers and historical rotor constants for the Enigma rotor datapath.
package enigma_pkg;

  localparam int unsigned AlphaDefault = 26;
  localparam int unsigned IdxWDefault  = 5;

  typedef enum logic [2:0] {
    StUncfg,
    StBuild,
    StReady,
    StBusy,
    StHold
  } rotor_state_e;

  // Operands are always < alpha, so one conditional subtract is enough.
  function automatic int unsigned mod_add(int unsigned a, int unsigned b, int unsigned alpha);
    int unsigned s;
    s = a + b;
    return (s >= alpha) ? s - alpha : s;
  endfunction

  function automatic int unsigned mod_sub(int unsigned a, int unsigned b, int unsigned alpha);
    int unsigned s;
    s = a + alpha - b;
    return (s >= alpha) ? s - alpha : s;
  endfunction

  localparam string RotorWiringI   = "EKMFLGDQVZNTOWYHXRUBIPCJSA";
  localparam string RotorWiringII  = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
  localparam string RotorWiringIII = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
  localparam string RotorWiringIV  = "ESOVPZJAYQUIRHXLNFTGKDCMWB";
  localparam string RotorWiringV   = "VZBRGITYUPSDNHLXAWMJQOFECK";

  localparam int unsigned RotorNotchI   = 16;
  localparam int unsigned RotorNotchII  = 4;
  localparam int unsigned RotorNotchIII = 21;
  localparam int unsigned RotorNotchIV  = 9;
  localparam int unsigned RotorNotchV   = 25;

endpackage

// File: rtl/rotor_stage_if.sv
// Input/output beat handshake bundle of one rotor stage.
interface rotor_stage_if
  import enigma_pkg::*;
#(
  parameter int unsigned IDX_W = IdxWDefault
) ();

  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_sym;
  logic             dec;
  logic             step_in;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_sym;
  logic             out_err;

  modport master (
    output in_valid, in_sym, dec, step_in, out_ready,
    input  in_ready, out_valid, out_sym, out_err
  );

  modport slave (
    input  in_valid, in_sym, dec, step_in, out_ready,
    output in_ready, out_valid, out_sym, out_err
  );

endinterface

// File: rtl/rotor_table_builder.sv
// Walks the forward wiring once, filling the inverse table and flagging
// out-of-range or duplicate entries.
module rotor_table_builder
  import enigma_pkg::*;
#(
  parameter int unsigned ALPHA = AlphaDefault,
  parameter int unsigned IDX_W = IdxWDefault
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ALPHA-1:0][IDX_W-1:0] wiring,
  output logic                        last,
  output logic                        fail,
  output logic [ALPHA-1:0][IDX_W-1:0] inv
);

  localparam logic [IDX_W:0] AlphaW = (IDX_W + 1)'(ALPHA);

  logic                        active_q;
  logic [IDX_W-1:0]            idx_q;
  logic                        err_q;
  logic [ALPHA-1:0]            seen_q;
  logic [ALPHA-1:0][IDX_W-1:0] inv_q;

  logic [IDX_W-1:0] w_cur;
  logic [IDX_W-1:0] w_sel;
  logic             w_ok;
  logic             cur_bad;

  always_comb begin
    w_cur   = wiring[idx_q];
    w_ok    = {1'b0, w_cur} < AlphaW;
    w_sel   = w_ok ? w_cur : '0;
    cur_bad = !w_ok || seen_q[w_sel];
  end

  assign last = active_q && (idx_q == IDX_W'(ALPHA - 1));
  // Includes the current entry so the final index is judged in the same cycle.
  assign fail = err_q || cur_bad;
  assign inv  = inv_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      seen_q   <= '0;
      inv_q    <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      idx_q    <= '0;
      err_q    <= 1'b0;
      seen_q   <= '0;
    end else if (active_q) begin
      if (w_ok) begin
        inv_q[w_sel]  <= idx_q;
        seen_q[w_sel] <= 1'b1;
      end
      err_q <= err_q || cur_bad;
      idx_q <= idx_q + IDX_W'(1);
      if (last) begin
        active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rotor_stage.sv
// One Enigma rotor: runtime-loaded wiring, stepping with notch carry and
// a single in-flight symbol with programmable extra latency.
module rotor_stage
  import enigma_pkg::*;
#(
  parameter int unsigned ALPHA = AlphaDefault,
  parameter int unsigned IDX_W = IdxWDefault,
  parameter int unsigned DLY_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_load,
  input  logic [ALPHA*IDX_W-1:0] cfg_wiring,
  input  logic [IDX_W-1:0]       cfg_pos,
  input  logic [IDX_W-1:0]       cfg_step,
  input  logic [IDX_W-1:0]       cfg_notch,
  input  logic [DLY_W-1:0]       cfg_delay,
  output logic                   cfg_done,
  output logic                   cfg_err,
  output logic                   configured,
  rotor_stage_if.slave           bus,
  output logic                   carry_out,
  output logic [IDX_W-1:0]       pos
);

  localparam logic [IDX_W:0] AlphaW = (IDX_W + 1)'(ALPHA);

  rotor_state_e state_q, state_d;

  logic [ALPHA-1:0][IDX_W-1:0] wiring_q;
  logic [ALPHA-1:0][IDX_W-1:0] inv;
  logic [IDX_W-1:0]            pos_q, start_pos_q, step_q, notch_q, out_sym_q;
  logic [DLY_W-1:0]            delay_q, cnt_q;
  logic                        out_err_q, carry_q, cfg_done_q, cfg_err_q, configured_q;

  logic             cfg_accept, cfg_bad, build_start, build_last, build_fail;
  logic             beat_accept, sym_ok;
  logic [IDX_W-1:0] pos_next, tbl_idx, tbl_val, result;

  assign cfg_accept  = cfg_load && ((state_q == StUncfg) || (state_q == StReady));
  assign cfg_bad     = ({1'b0, cfg_step} >= AlphaW) || ({1'b0, cfg_pos} >= AlphaW);
  assign build_start = cfg_accept && !cfg_bad;

  assign bus.in_ready  = (state_q == StReady) && !cfg_load;
  assign beat_accept   = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q == StHold);
  assign bus.out_sym   = out_sym_q;
  assign bus.out_err   = out_err_q;

  assign cfg_done   = cfg_done_q;
  assign cfg_err    = cfg_err_q;
  assign configured = configured_q;
  assign carry_out  = carry_q;
  assign pos        = pos_q;

  rotor_table_builder #(
    .ALPHA(ALPHA),
    .IDX_W(IDX_W)
  ) u_builder (
    .clk   (clk),
    .reset (reset),
    .start (build_start),
    .wiring(wiring_q),
    .last  (build_last),
    .fail  (build_fail),
    .inv   (inv)
  );

  // Out-of-range symbols bypass the tables, so the lookup index is forced in range.
  always_comb begin
    sym_ok   = {1'b0, bus.in_sym} < AlphaW;
    pos_next = bus.step_in ? IDX_W'(mod_add(32'(pos_q), 32'(step_q), ALPHA)) : pos_q;
    tbl_idx  = sym_ok ? IDX_W'(mod_add(32'(bus.in_sym), 32'(pos_next), ALPHA)) : '0;
    tbl_val  = bus.dec ? inv[tbl_idx] : wiring_q[tbl_idx];
    result   = IDX_W'(mod_sub(32'(tbl_val), 32'(pos_next), ALPHA));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StUncfg: begin
        if (cfg_accept) state_d = cfg_bad ? StUncfg : StBuild;
      end
      StBuild: begin
        if (build_last) state_d = build_fail ? StUncfg : StReady;
      end
      StReady: begin
        if (cfg_accept) begin
          state_d = cfg_bad ? StUncfg : StBuild;
        end else if (beat_accept) begin
          state_d = (delay_q == '0) ? StHold : StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == DLY_W'(1)) state_d = StHold;
      end
      StHold: begin
        if (bus.out_ready) state_d = StReady;
      end
      default: state_d = StUncfg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StUncfg;
      wiring_q     <= '0;
      pos_q        <= '0;
      start_pos_q  <= '0;
      step_q       <= '0;
      notch_q      <= '0;
      delay_q      <= '0;
      cnt_q        <= '0;
      out_sym_q    <= '0;
      out_err_q    <= 1'b0;
      carry_q      <= 1'b0;
      cfg_done_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
      configured_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_done_q <= 1'b0;
      carry_q    <= 1'b0;

      if (cfg_accept) begin
        wiring_q     <= cfg_wiring;
        start_pos_q  <= cfg_pos;
        step_q       <= cfg_step;
        notch_q      <= cfg_notch;
        delay_q      <= cfg_delay;
        configured_q <= 1'b0;
        cfg_err_q    <= cfg_bad;
        cfg_done_q   <= cfg_bad;
      end

      if ((state_q == StBuild) && build_last) begin
        cfg_done_q   <= 1'b1;
        cfg_err_q    <= build_fail;
        configured_q <= !build_fail;
        if (!build_fail) pos_q <= start_pos_q;
      end

      if (beat_accept) begin
        out_err_q <= !sym_ok;
        out_sym_q <= sym_ok ? result : bus.in_sym;
        cnt_q     <= delay_q;
        if (sym_ok) begin
          pos_q   <= pos_next;
          carry_q <= bus.step_in && (step_q != '0) && (pos_q == notch_q);
        end
      end else if (state_q == StBusy) begin
        cnt_q <= cnt_q - DLY_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rotor_stage.sv
// Self-checking bench for rotor_stage: vector table, corner sequences and randomized beats.
module tb_rotor_stage;
  import enigma_pkg::*;

  localparam int A = 26;

  logic           clk = 1'b0;
  logic           reset;
  logic           cfg_load;
  logic [A*5-1:0] cfg_wiring;
  logic [4:0]     cfg_pos, cfg_step, cfg_notch;
  logic [7:0]     cfg_delay;
  logic           cfg_done, cfg_err, configured, carry_out;
  logic [4:0]     pos;

  rotor_stage_if #(.IDX_W(5)) bus ();

  rotor_stage #(
    .ALPHA(26),
    .IDX_W(5),
    .DLY_W(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_load  (cfg_load),
    .cfg_wiring(cfg_wiring),
    .cfg_pos   (cfg_pos),
    .cfg_step  (cfg_step),
    .cfg_notch (cfg_notch),
    .cfg_delay (cfg_delay),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .configured(configured),
    .bus       (bus),
    .carry_out (carry_out),
    .pos       (pos)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int wire_tab[A];
  int m_w[A];
  int m_pos, m_step, m_notch, m_delay;

  typedef struct {
    int x;
    int d;
    int st;
    int exp_sym;
    int exp_err;
    int exp_pos;
  } vec_t;

  vec_t vecs[6];
  string rotors[5];

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void load_rotor(input string s);
    for (int i = 0; i < A; i++) wire_tab[i] = int'(s[i]) - 65;
  endfunction

  // Reference: plain modular arithmetic, inverse found by searching the wiring.
  task automatic model_beat(input int x, input int d, input int st,
                            output int o_sym, output int o_err, output int o_pos,
                            output int o_carry);
    int p2, idx, v;
    if (x >= A) begin
      o_sym = x; o_err = 1; o_pos = m_pos; o_carry = 0;
    end else begin
      p2      = (st != 0) ? (m_pos + m_step) % A : m_pos;
      o_carry = ((st != 0) && (m_step != 0) && (m_pos == m_notch)) ? 1 : 0;
      idx     = (x + p2) % A;
      v       = 0;
      if (d != 0) begin
        for (int j = 0; j < A; j++) if (m_w[j] == idx) v = j;
      end else begin
        v = m_w[idx];
      end
      o_sym = (v - p2 + A) % A;
      o_err = 0;
      o_pos = p2;
    end
  endtask

  task automatic configure(input string nm, input int p, input int st, input int nt,
                           input int dl, input int exp_err, input int exp_lat);
    int n;
    for (int i = 0; i < A; i++) cfg_wiring[i*5 +: 5] = 5'(wire_tab[i]);
    cfg_pos   = 5'(p);
    cfg_step  = 5'(st);
    cfg_notch = 5'(nt);
    cfg_delay = 8'(dl);
    cfg_load  = 1'b1;
    #1;
    check({nm, "_in_ready_blocked"}, int'(bus.in_ready), 0);
    @(posedge clk); #1;
    cfg_load = 1'b0;
    n = 1;
    while (!cfg_done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, "_done_latency"}, n, exp_lat);
    check({nm, "_cfg_err"}, int'(cfg_err), exp_err);
    check({nm, "_configured"}, int'(configured), (exp_err != 0) ? 0 : 1);
    if (exp_err == 0) begin
      check({nm, "_start_pos"}, int'(pos), p);
      m_w = wire_tab; m_pos = p; m_step = st; m_notch = nt; m_delay = dl;
    end
    @(posedge clk); #1;
    check({nm, "_done_pulse"}, int'(cfg_done), 0);
  endtask

  task automatic beat(input string nm, input int x, input int d, input int st, input int hold,
                      input int exp_sym, input int exp_err, input int exp_pos,
                      input int exp_carry, input int exp_lat);
    int lat;
    check({nm, "_in_ready"}, int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_sym   = 5'(x);
    bus.dec      = 1'(d);
    bus.step_in  = 1'(st);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check({nm, "_pos"}, int'(pos), exp_pos);
    check({nm, "_carry"}, int'(carry_out), exp_carry);
    lat = 1;
    while (!bus.out_valid && lat < 300) begin
      check({nm, "_busy_in_ready"}, int'(bus.in_ready), 0);
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, lat, exp_lat);
    check({nm, "_out_sym"}, int'(bus.out_sym), exp_sym);
    check({nm, "_out_err"}, int'(bus.out_err), exp_err);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check({nm, "_hold_valid"}, int'(bus.out_valid), 1);
      check({nm, "_hold_sym"}, int'(bus.out_sym), exp_sym);
      check({nm, "_hold_in_ready"}, int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({nm, "_valid_drop"}, int'(bus.out_valid), 0);
    check({nm, "_carry_once"}, int'(carry_out), 0);
    check({nm, "_ready_again"}, int'(bus.in_ready), 1);
    check({nm, "_pos_kept"}, int'(pos), exp_pos);
  endtask

  task automatic model_run(input string nm, input int x, input int d, input int st,
                           input int hold);
    int e_sym, e_err, e_pos, e_carry;
    model_beat(x, d, st, e_sym, e_err, e_pos, e_carry);
    beat(nm, x, d, st, hold, e_sym, e_err, e_pos, e_carry, m_delay + 1);
    m_pos = e_pos;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    cfg_load      = 1'b0;
    cfg_wiring    = '0;
    cfg_pos       = '0;
    cfg_step      = '0;
    cfg_notch     = '0;
    cfg_delay     = '0;
    bus.in_valid  = 1'b0;
    bus.in_sym    = '0;
    bus.dec       = 1'b0;
    bus.step_in   = 1'b0;
    bus.out_ready = 1'b0;
    rotors[0] = RotorWiringI;
    rotors[1] = RotorWiringII;
    rotors[2] = RotorWiringIII;
    rotors[3] = RotorWiringIV;
    rotors[4] = RotorWiringV;

    // Rotor I, pos 0, step 1: hand-derived results.
    vecs[0] = '{x: 0,  d: 0, st: 1, exp_sym: 9,  exp_err: 0, exp_pos: 1};
    vecs[1] = '{x: 9,  d: 1, st: 0, exp_sym: 0,  exp_err: 0, exp_pos: 1};
    vecs[2] = '{x: 30, d: 0, st: 1, exp_sym: 30, exp_err: 1, exp_pos: 1};
    vecs[3] = '{x: 25, d: 0, st: 1, exp_sym: 8,  exp_err: 0, exp_pos: 2};
    vecs[4] = '{x: 3,  d: 0, st: 0, exp_sym: 4,  exp_err: 0, exp_pos: 2};
    vecs[5] = '{x: 4,  d: 1, st: 0, exp_sym: 3,  exp_err: 0, exp_pos: 2};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_cfg_done", int'(cfg_done), 0);
    check("reset_cfg_err", int'(cfg_err), 0);
    check("reset_configured", int'(configured), 0);
    check("reset_in_ready", int'(bus.in_ready), 0);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_pos", int'(pos), 0);
    check("reset_carry", int'(carry_out), 0);

    load_rotor(RotorWiringI);
    configure("rotor1_plain", 0, 0, 0, 0, 0, A + 1);
    beat("rotor1_a_to_e", 0, 0, 0, 0, 4, 0, 0, 0, 1);

    configure("rotor1_step", 0, 1, RotorNotchI, 0, 0, A + 1);
    for (int i = 0; i < 6; i++) begin
      beat($sformatf("vec%0d", i), vecs[i].x, vecs[i].d, vecs[i].st, 0,
           vecs[i].exp_sym, vecs[i].exp_err, vecs[i].exp_pos, 0, 1);
    end

    for (int i = 0; i < A; i++) wire_tab[i] = 0;
    configure("zero_wiring", 0, 0, 0, 0, 1, A + 1);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("zero_wiring_in_ready", int'(bus.in_ready), 0);
      check("zero_wiring_out_valid", int'(bus.out_valid), 0);
    end
    bus.in_valid = 1'b0;
    load_rotor(RotorWiringI);
    configure("bad_step", 0, 26, 0, 0, 1, 1);

    configure("notch", 15, 1, RotorNotchI, 0, 0, A + 1);
    beat("notch_first", 0, 0, 1, 0, 7, 0, 16, 0, 1);
    beat("notch_second", 0, 0, 1, 0, 0, 0, 17, 1, 1);

    configure("delay3", 0, 0, 0, 3, 0, A + 1);
    beat("delay3_hold", 0, 0, 0, 5, 4, 0, 0, 0, 4);
    beat("delay3_badsym", 30, 0, 1, 0, 30, 1, 0, 0, 4);

    configure("busy_reset", 5, 1, 0, 3, 0, A + 1);
    bus.in_valid = 1'b1;
    bus.in_sym   = 5'd2;
    bus.step_in  = 1'b1;
    bus.dec      = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("busy_reset_pos_stepped", int'(pos), 6);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("busy_reset_out_valid", int'(bus.out_valid), 0);
    check("busy_reset_out_sym", int'(bus.out_sym), 0);
    check("busy_reset_out_err", int'(bus.out_err), 0);
    check("busy_reset_configured", int'(configured), 0);
    check("busy_reset_cfg_err", int'(cfg_err), 0);
    check("busy_reset_in_ready", int'(bus.in_ready), 0);
    check("busy_reset_pos", int'(pos), 0);
    check("busy_reset_carry", int'(carry_out), 0);
    repeat (4) begin
      @(posedge clk); #1;
      check("busy_reset_stays_idle", int'(bus.out_valid), 0);
    end

    for (int r = 0; r < 5; r++) begin
      load_rotor(rotors[$urandom_range(0, 4)]);
      configure($sformatf("rand_cfg%0d", r), int'($urandom_range(0, 25)),
                int'($urandom_range(0, 25)), int'($urandom_range(0, 25)),
                int'($urandom_range(0, 3)), 0, A + 1);
      for (int b = 0; b < 30; b++) begin
        int x;
        x = ($urandom_range(0, 7) == 0) ? int'($urandom_range(26, 31))
                                        : int'($urandom_range(0, 25));
        model_run($sformatf("rand%0d_%0d", r, b), x, int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rotor_stage.md
# rotor_stage

Parametrised Enigma rotor stage with a configurable alphabet size, a runtime-loaded wiring permutation, a hardware-built inverse table for decode, programmable stepping with notch carry, and valid/ready handshakes on both sides. Stages chain through `carry_out` → `step_in` to form the rotor stack between the plugboard and the reflector.

## Interface
- `ALPHA`, 26: alphabet size; symbols are indices 0..ALPHA-1.
- `IDX_W`, 5: symbol width; 2^IDX_W ≥ ALPHA.
- `DLY_W`, 8: delay counter width.
- `clk` in 1: clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous active-high reset.
- `cfg_load` in 1: start configuration.
- `cfg_wiring` in ALPHA*IDX_W: forward table; entry i is at bits [i*IDX_W +: IDX_W].
- `cfg_pos`, `cfg_step`, `cfg_notch` in IDX_W: start position, step amount, turnover position.
- `cfg_delay` in DLY_W: extra latency cycles D.
- `cfg_done` out 1: one-cycle pulse when the build finishes, pass or fail.
- `cfg_err` out 1: last configuration rejected; sticky until the next `cfg_load`.
- `configured` out 1: a valid table is loaded.
- `in_valid` in 1, `in_ready` out 1, `in_sym` in IDX_W, `dec` in 1, `step_in` in 1: input beat.
- `out_valid` out 1, `out_ready` in 1, `out_sym` out IDX_W, `out_err` out 1: output beat.
- `carry_out` out 1: one-cycle turnover pulse to the next stage.
- `pos` out IDX_W: current rotor position.

## Operation
- States: UNCFG, BUILD, READY, BUSY, HOLD.
- Reset (any state): state UNCFG. All outputs 0. `pos`, tables, seen bitmap and counters are cleared.
- `cfg_load` is accepted only in UNCFG or READY; it is ignored elsewhere.
  - On accept: latch all cfg inputs, clear `cfg_err`, clear `configured`, enter BUILD.
  - If `cfg_step` ≥ ALPHA or `cfg_pos` ≥ ALPHA: go to UNCFG with `cfg_err`=1 and `cfg_done` pulsed.
- BUILD lasts ALPHA cycles, i = 0..ALPHA-1.
  - Each cycle writes `inv[W[i]] = i` and sets `seen[W[i]]`.
  - If W[i] ≥ ALPHA or is already seen, set the error flag.
  - At the end, pulse `cfg_done`. On error go to UNCFG with `cfg_err`=1. Otherwise go to READY with `configured`=1 and `pos` = `cfg_pos`.
- `in_ready` = (state==READY) && !`cfg_load`. When `cfg_load` and `in_valid` arrive together in READY, the configuration wins.
- Accept when `in_valid` && `in_ready`; latch `in_sym`, `dec` and `step_in`.
  - Step first: p' = `step_in` ? (pos + step) mod ALPHA : pos.
  - `carry_out` pulses when `step_in`=1, step≠0 and the old pos == notch.
  - Forward: out = (W[(x+p') mod A] − p') mod A. Decode (`dec`=1) uses inv[] in place of W[].
  - If x ≥ ALPHA: `out_err`=1, `out_sym`=x, no step, no carry.
- All mod arithmetic is done at IDX_W+1 bits with a single conditional subtract of ALPHA. Operands are always < ALPHA.

## Timing
- Accept at cycle t:
  - `pos` and `carry_out` update at t+1.
  - The result is registered at t+1.
  - If D=0, `out_valid` rises at t+1. Otherwise state is BUSY for D cycles and `out_valid` rises at t+1+D.
- HOLD: `out_valid`, `out_sym` and `out_err` stay stable until `out_ready`=1. The beat completes on that edge and the next cycle is READY.
- `in_ready`=0 in BUILD, BUSY and HOLD, so at most one symbol is in flight. Maximum throughput is one symbol per D+2 cycles.
- `cfg_done` pulses in the cycle after the final BUILD index.
- Reset mid-BUILD, mid-BUSY or mid-HOLD: the pending beat is dropped, `out_valid` goes to 0 next cycle, and the block returns to UNCFG.

## Structure
- Package `enigma_pkg`:
  - state enum;
  - `mod_add`/`mod_sub` functions parametrised by ALPHA;
  - default ALPHA and IDX_W constants;
  - rotor I–V wiring and notch constants for tests.
- Sub-module `rotor_table_builder`: owns the BUILD counter, the inv[] register file, the seen bitmap, and error/done generation. `rotor_stage` owns the FSM, position, delay counter and datapath.

## Test plan
- Rotor I wiring EKMFLGDQVZNTOWYHXRUBIPCJSA, pos 0, step 0, D 0; send A (0) → `out_sym`=4 (E) at t+1, `pos`=0, `cfg_done` after 26 build cycles.
- Same wiring, pos 0, step 1, `step_in`=1; send A → J (9), `pos`=1. Reload, send J with `dec`=1 → A (0).
- Wiring all zeros → `cfg_err`=1, `configured`=0, `in_ready` stays 0. `cfg_step`=26 → immediate `cfg_err`.
- Notch 16, pos 15, step 1: first symbol → `pos`=16, no carry. Second symbol → `pos`=17 and a single `carry_out` pulse.
- D=3 with `out_ready` held low 5 cycles: `out_valid` at t+4, `out_sym` stable, `in_ready`=0 until the handshake. `in_sym`=30 → `out_err`=1, `out_sym`=30, `pos` unchanged.
- Assert `reset` during BUSY → next cycle all outputs 0, state UNCFG, `configured`=0.
